fpu_floor_arbiter: RTL

- Shares one pipelined floor unit (32-bit IEEE single in, 32-bit result out, fixed registered latency) between N_REQ requesters, e.g. integer-issue and FP-issue lanes.
- Round-robin arbitration, in-flight tag tracking, and a credit-protected result FIFO, so consumer backpressure never drops a result.
- Sits between the issue stage and writeback in the FPU cluster.

---
 rtl/fpu_floor_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fpu_floor_arbiter.sv
// Round-robin arbiter sharing one pipelined floor unit between N_REQ requesters,
// with in-flight tag tracking and a credit-protected result FIFO. Optional macro: FPU_FLOOR_ARB_PERF_EN.
module fpu_floor_arbiter #(
   parameter int N_REQ   = 2,
   parameter int LATENCY = 1,
   parameter int DEPTH   = 4,
   localparam int IDW    = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_REQ-1:0]    req_valid_i,
   output logic [N_REQ-1:0]    req_ready_o,
   input  logic [32*N_REQ-1:0] req_data_i,
   output logic [31:0]         unit_a_o,
   input  logic [31:0]         unit_c_i,
   output logic                resp_valid_o,
   input  logic                resp_ready_i,
   output logic [31:0]         resp_data_o,
   output logic [IDW-1:0]      resp_id_o,
`ifdef FPU_FLOOR_ARB_PERF_EN
   output logic [31:0]         perf_stall_cnt_o,
`endif
   output logic                busy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + LATENCY + 1);

   logic [IDW-1:0]     rr_q, rr_d;
   logic [LATENCY-1:0] infl_vld_q;
   logic [IDW-1:0]     infl_id_q [LATENCY];
   logic [31:0]        mem_data_q [DEPTH];
   logic [IDW-1:0]     mem_id_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      infl_cnt;
   logic               issue_ok;
   logic               grant_any;
   logic [IDW-1:0]     grant_id;
   logic               push, pop, empty, full;

   // Credit counts everything issued and not yet popped; a same-cycle pop frees credit next cycle.
   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
         infl_cnt = infl_cnt + CW'(infl_vld_q[i]);
      end
      issue_ok = (cnt_q + infl_cnt) < CW'(DEPTH);
   end

   // Two passes: first requesters at or above the pointer, then the wrapped-around ones.
   always_comb begin
      grant_any   = 1'b0;
      grant_id    = '0;
      req_ready_o = '0;
      unit_a_o    = '0;
      if (issue_ok) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid_i[i] && (i >= int'(rr_q))) begin
               grant_any = 1'b1;
               grant_id  = IDW'(i);
            end
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid_i[i]) begin
               grant_any = 1'b1;
               grant_id  = IDW'(i);
            end
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_any && (grant_id == IDW'(i))) begin
            req_ready_o[i] = 1'b1;
            unit_a_o       = req_data_i[32*i +: 32];
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant_any) begin
         rr_d = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   assign push  = infl_vld_q[LATENCY-1];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign pop   = !empty && resp_ready_i;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         infl_vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            infl_id_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         rr_q          <= rr_d;
         infl_vld_q[0] <= grant_any;
         infl_id_q[0]  <= grant_id;
         for (int i = LATENCY - 1; i > 0; i--) begin
            infl_vld_q[i] <= infl_vld_q[i-1];
            infl_id_q[i]  <= infl_id_q[i-1];
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= unit_c_i;
         mem_id_q[wr_ptr_q]   <= infl_id_q[LATENCY-1];
      end
   end

   assign resp_valid_o = !empty;
   assign resp_data_o  = empty ? '0 : mem_data_q[rd_ptr_q];
   assign resp_id_o    = empty ? '0 : mem_id_q[rd_ptr_q];
   assign busy_o       = (|infl_vld_q) | !empty;

`ifdef FPU_FLOOR_ARB_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((|req_valid_i) && !grant_any && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign perf_stall_cnt_o = stall_q;
`endif

`ifndef SYNTHESIS
   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
`endif

endmodule
